// File: rtl/gpio_in_event.sv
// gpio_in_event: synchronize, debounce and edge-detect GPIO pin samples into sticky status and a level irq.
// Latency: gpio_val/status move STABLE ticks after sync2 changes, irq one clock later; no backpressure.
module gpio_in_event #(
   parameter int WIDTH  = 32,
   parameter int STABLE = 2,
   parameter int DIV_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] gpio_in,
   input  logic [DIV_W-1:0] sample_div,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] status_clr,
   output logic [WIDTH-1:0] gpio_val,
   output logic [WIDTH-1:0] status,
   output logic             irq
);

   localparam logic [1:0]       CNT_LAST = 2'(STABLE - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [DIV_W-1:0] div_cnt;
   logic             primed;
   logic             tick;
   logic [1:0]       cnt     [WIDTH];
   logic [1:0]       cnt_nxt [WIDTH];
   logic [WIDTH-1:0] val_nxt;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] status_nxt;

   // >= rather than == so lowering sample_div below the running count ticks at once.
   assign tick = (div_cnt >= sample_div);

   always_comb begin
      val_nxt = gpio_val;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (tick) begin
            if (!primed) begin
               val_nxt[i] = sync2[i];
               cnt_nxt[i] = 2'd0;
            end else if (sync2[i] == gpio_val[i]) begin
               cnt_nxt[i] = 2'd0;
            end else if (cnt[i] == CNT_LAST) begin
               val_nxt[i] = sync2[i];
               cnt_nxt[i] = 2'd0;
            end else begin
               cnt_nxt[i] = cnt[i] + 2'd1;
            end
         end
      end
   end

   // The priming load is not an edge: pins held high through reset must not raise events.
   assign evt        = primed ? ((val_nxt & ~gpio_val & rise_en) | (~val_nxt & gpio_val & fall_en))
                              : '0;
   assign status_nxt = (status & ~status_clr) | evt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         div_cnt  <= '0;
         primed   <= 1'b0;
         gpio_val <= '0;
         status   <= '0;
         irq      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= 2'd0;
      end else begin
         sync1    <= gpio_in;
         sync2    <= sync1;
         div_cnt  <= tick ? '0 : div_cnt + DIV_ONE;
         if (tick) primed <= 1'b1;
         gpio_val <= val_nxt;
         status   <= status_nxt;
         irq      <= |status;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule
